uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised UART receiver, the successor to the team's fixed 8N1 receiver. Adds:
- configurable data width and stop-bit count
- false-start rejection and framing-error detection
- break-safe recovery
- a valid/ready output holding register with overrun reporting

It sits between the external rx pin and a bus-side consumer, such as a bus slave register file or a FIFO.

Parameters:
CLOCKS_PER_PULSE, 16, clk cycles per bit; must be even and >= 4
DATA_WIDTH, 8, data bits per frame (5..16), LSB first
STOP_BITS, 1, number of stop bits checked (1 or 2)
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd

Ports:
clk  input  1  single clock domain
rst  input  1  asynchronous active-high reset
rx  input  1  asynchronous serial line, idle high
m_valid  output  1  data_out/flags hold an unconsumed word
m_ready  input  1  consumer accepts the word when m_valid & m_ready
data_out  output  DATA_WIDTH  received word
frame_err  output  1  qualified by m_valid: a stop bit was sampled low
parity_err  output  1  qualified by m_valid: parity mismatch; constant 0 without the macro
overrun  output  1  one-cycle pulse: a completed word was dropped
busy  output  1  high in every state other than IDLE

Behaviour:
Clock and reset:
- One clock: clk. Reset is asynchronous and active-high on rst.
- Reset values: m_valid=0, data_out=0, frame_err=0, parity_err=0, overrun=0, busy=0, state=IDLE, all counters 0, both synchroniser flops =1.
- Reset mid-frame abandons the frame. No word is delivered.

Input synchronisation:
- rx passes through a 2-flop synchroniser to give rx_s. All sampling uses rx_s.

Counters:
- Bit-clock counter width is $clog2(CLOCKS_PER_PULSE).
- Bit counter width is $clog2(DATA_WIDTH+1).
- The counter wraps to 0 on every bit boundary.

State machine (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE):
- IDLE: when rx_s==0, go to START with counter=0.
- START: at counter==CLOCKS_PER_PULSE/2-1, sample rx_s.
  - 0: go to DATA with counter=0.
  - 1: glitch; go to IDLE. No flags are raised.
- DATA: at each counter==CLOCKS_PER_PULSE-1, shift rx_s into the shift register (LSB first).
  - After DATA_WIDTH samples, go to PARITY (macro defined) or STOP.
- PARITY: sample at CLOCKS_PER_PULSE-1. Then go to STOP.
- STOP: sample STOP_BITS times, each at CLOCKS_PER_PULSE-1. Any low sample sets a pending frame error.
  - On the cycle of the last stop sample, commit the word.
  - Then go to WAIT_IDLE if a frame error occurred, otherwise go to IDLE.
  - Going to IDLE at mid-stop-bit permits back-to-back frames.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. A held break yields exactly one word.

Commit and handshake:
- Commit loads data_out, frame_err and parity_err, and sets m_valid=1 on the next edge.
- When m_valid & m_ready, m_valid clears on the next edge.
- If commit coincides with the handshake, the new word loads and m_valid stays 1. No overrun is raised.
- If commit occurs with m_valid=1 and m_ready=0:
  - the new word is dropped
  - the held word and its flags are unchanged
  - overrun pulses high for 1 cycle.

Latency:
- The commit edge falls 2 + CLOCKS_PER_PULSE/2 + (DATA_WIDTH+P+STOP_BITS-1)×CLOCKS_PER_PULSE + CLOCKS_PER_PULSE cycles after the falling edge at the rx pin, ±1 cycle. P = 1 with parity, else 0.

Optional Feature:
UART_RX_PARITY_EN
- Defined: one parity bit is expected after the data bits. parity_err = (XOR of data bits ^ parity bit ^ PARITY_ODD) != 0. The frame is one bit longer.
- Undefined: there is no PARITY state and no parity bit. parity_err is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - the state encoding localparams (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
  - the parity sense constants EVEN=0, ODD=1
  - the helper function for counter width.
- One sub-module: uart_rx_sync, a 2-flop synchroniser with a parametrised reset value (1 here). It is reusable by the team's future uart blocks.

Test Plan:
1. 8N1, CLOCKS_PER_PULSE=16, send 0xA5 with m_ready=1 -> m_valid high 1 cycle, data_out=0xA5, frame_err=0, commit about 154 cycles after the start edge.
2. 4-cycle low glitch on rx -> no m_valid; busy returns to 0 within 10 cycles.
3. Frame 0x3C with stop bit 0, then rx held low for 3 frame times -> exactly one word with frame_err=1 (data 0x3C); after rx returns high, the next frame 0x55 is received with frame_err=0.
4. m_ready=0, back-to-back frames 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once; on raising m_ready, 0x11 is consumed and m_valid drops.
5. UART_RX_PARITY_EN defined, even parity, data 0x07 with parity bit 0 -> parity_err=1; repeat with parity bit 1 -> parity_err=0.
6. Assert rst during DATA bit 4 of a frame -> all outputs 0, no word delivered; the next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart blocks: receiver state encoding, parity
// sense constants and the counter-width helper.
// Latency: n/a (package). Backpressure: n/a (package).
package uart_pkg;

   // Receiver frame states. PARITY is only entered when parity is compiled in.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   // Parity sense selectors.
   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// parametrised reset value so an idle-high line does not look active out of reset.
// Latency: 2 clk cycles. Backpressure: none (free running).
// Ports: clk, rst (async active-high), d_i (async input), q_o (synchronised output).
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with false-start rejection, framing-error
// detection, break-safe recovery and a valid/ready holding register.
// Latency: commit ~2 + CPP/2 + (DATA_WIDTH+P+STOP_BITS)*CPP cycles after the start edge.
// Backpressure: one holding word; a word completing while it is unconsumed is
// dropped and reported with a one-cycle overrun pulse.
// Optional feature: define UART_RX_PARITY_EN to expect one parity bit per frame.
// Ports: clk, rst (async active-high), rx (serial in, idle high),
//        m_valid/m_ready (output handshake), data_out, frame_err, parity_err
//        (qualified by m_valid), overrun (pulse), busy (not IDLE).
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = 16,
   parameter int DATA_WIDTH       = 8,
   parameter int STOP_BITS        = 1,
   parameter int PARITY_ODD       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CW = cnt_width(CLOCKS_PER_PULSE);
   localparam int BW = cnt_width(DATA_WIDTH + 1);

   localparam logic [CW-1:0] CNT_HALF  = CW'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   // Reject unusable configurations at elaboration.
   if (CLOCKS_PER_PULSE < 4 || (CLOCKS_PER_PULSE % 2) != 0) begin : g_bad_cpp
      $error("CLOCKS_PER_PULSE must be even and >= 4");
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 16) begin : g_bad_dw
      $error("DATA_WIDTH must be 5..16");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
      $error("STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != int'(EVEN) && PARITY_ODD != int'(ODD)) begin : g_bad_par
      $error("PARITY_ODD must be 0 or 1");
   end

   // ---------------------------------------------------------------------
   // Input synchroniser: resets high so reset does not fake a start bit.
   // ---------------------------------------------------------------------
   logic rx_s;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx),
      .q_o (rx_s)
   );

   // ---------------------------------------------------------------------
   // Frame state machine
   // ---------------------------------------------------------------------
   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic                    ferr_pend_q, ferr_pend_d;
   logic                    commit;
   logic                    commit_ferr;
   logic                    commit_perr;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_SENSE = (PARITY_ODD != 0) ? ODD : EVEN;
   logic                    par_q, par_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         ferr_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         ferr_pend_q <= ferr_pend_d;
`ifdef UART_RX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      ferr_pend_d = ferr_pend_q;
      commit      = 1'b0;
      commit_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d       = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d       = '0;
            bit_d       = '0;
            ferr_pend_d = 1'b0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Mid-start-bit check: a high line here was a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               // LSB arrives first, so shift in from the top.
               shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               commit_ferr = ferr_pend_q | ~rx_s;
               ferr_pend_d = commit_ferr;
               if (bit_q == STOP_LAST) begin
                  // Leave at mid-stop-bit so a following start edge is not missed;
                  // a low stop may be a break, so wait for the line to recover.
                  commit  = 1'b1;
                  bit_d   = '0;
                  state_d = commit_ferr ? WAIT_IDLE : IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign commit_perr = (^shreg_q) ^ par_q ^ PAR_SENSE;
`else
   assign commit_perr = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Output holding register
   // ---------------------------------------------------------------------
   logic                  m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  ferr_q, ferr_d;
   logic                  perr_q, perr_d;
   logic                  ovr_q, ovr_d;

   always_comb begin
      m_valid_d = m_valid_q;
      data_d    = data_q;
      ferr_d    = ferr_q;
      perr_d    = perr_q;
      ovr_d     = 1'b0;
      if (m_valid_q && m_ready) m_valid_d = 1'b0;
      if (commit) begin
         // A word being consumed this cycle frees the register for the new one.
         if (!m_valid_q || m_ready) begin
            m_valid_d = 1'b1;
            data_d    = shreg_q;
            ferr_d    = commit_ferr;
            perr_d    = commit_perr;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         data_q    <= '0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         data_q    <= data_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign data_out   = data_q;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: frames are built from their bit-level
// description, expected words are queued at issue time and a monitor pops
// them on every handshake.
module tb_uart_rx_frame;

   localparam int CPP  = 16;
   localparam int DW   = 8;
   localparam int SB   = 1;
   localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int EXP_LAT = 2 + CPP/2 + (DW + P + SB - 1) * CPP + CPP;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx;
   logic          m_ready;
   logic          m_valid;
   logic [DW-1:0] data_out;
   logic          frame_err;
   logic          parity_err;
   logic          overrun;
   logic          busy;

   always #5 clk = ~clk;

   uart_rx_frame #(
      .CLOCKS_PER_PULSE (CPP),
      .DATA_WIDTH       (DW),
      .STOP_BITS        (SB),
      .PARITY_ODD       (PODD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .data_out   (data_out),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          ferr;
      logic          perr;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;

   int checks_total = 0;
   int checks_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: parity error when the ones-count over data, parity bit
   // and sense is odd.
   function automatic logic model_perr(input logic [DW-1:0] d, input logic pbit);
`ifdef UART_RX_PARITY_EN
      return ((($countones(d) + int'(pbit) + PODD) % 2) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic good_parity(input logic [DW-1:0] d);
      return logic'(($countones(d) + PODD) % 2);
   endfunction

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   int   cyc = 0;
   int   ovr_cnt = 0;
   int   rise_cyc = -1;
   int   run_len = 0;
   int   last_len = 0;
   logic mv_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         mv_prev = 1'b0;
         run_len = 0;
      end else begin
         if (overrun) ovr_cnt++;
         if (m_valid && !mv_prev) rise_cyc = cyc;
         if (m_valid) run_len++;
         else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
         end
         mv_prev = m_valid;
         if (m_valid && m_ready) begin
            check("word_was_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e_mon = exp_q.pop_front();
               check("data_out", data_out, e_mon.data);
               check("frame_err", frame_err, e_mon.ferr);
               check("parity_err", parity_err, e_mon.perr);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Consumer ready driver
   // ------------------------------------------------------------------
   logic ready_force = 1'b1;
   logic ready_val   = 1'b1;

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic hold_bit(input logic v);
      rx = v;
      repeat (CPP) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic pbit,
                             input logic sbit, input bit expect_word);
      exp_t e;
      e.data = d;
      e.ferr = (sbit == 1'b0);
      e.perr = model_perr(d, pbit);
      if (expect_word) exp_q.push_back(e);
      hold_bit(1'b0);
      for (int i = 0; i < DW; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      hold_bit(pbit);
`endif
      for (int i = 0; i < SB; i++) hold_bit((i == 0) ? sbit : 1'b1);
      rx = 1'b1;
   endtask

   task automatic wait_drain(input string tag, input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({"drained_", tag}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got hang, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   initial begin
      int lat;
      int ovr0;
      logic [DW-1:0] d;
      logic sb_v;
      logic pb;

      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      idle(5);

      // 1: single clean frame, latency and one-cycle valid pulse
      rise_cyc = -1;
      lat = cyc;
      send_frame(8'hA5, good_parity(8'hA5), 1'b1, 1'b1);
      idle(4);
      lat = rise_cyc - lat;
      check($sformatf("latency_%0d_within_1_of_%0d", lat, EXP_LAT),
            (rise_cyc >= 0 && lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1);
      check("valid_pulse_len", last_len, 1);
      wait_drain("t1", 200);

      // 2: short glitch is rejected
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      check("glitch_busy_rise", busy, 1);
      idle(10);
      check("glitch_busy_clear", busy, 0);
      check("glitch_no_valid", m_valid, 0);

      // 3: framing error followed by a held break, then recovery
      send_frame(8'h3C, good_parity(8'h3C), 1'b0, 1'b1);
      rx = 1'b0;
      repeat (3 * (1 + DW + P + SB) * CPP) @(posedge clk);
      #1;
      check("break_busy", busy, 1);
      idle(2 * CPP);
      check("break_recovered_idle", busy, 0);
      send_frame(8'h55, good_parity(8'h55), 1'b1, 1'b1);
      wait_drain("t3", 300);

      // 4: overrun with consumer stalled
      ready_val = 1'b0;
      idle(2);
      ovr0 = ovr_cnt;
      send_frame(8'h11, good_parity(8'h11), 1'b1, 1'b1);
      send_frame(8'h22, good_parity(8'h22), 1'b1, 1'b0);
      idle(2 * CPP);
      check("ovr_held_data", data_out, 8'h11);
      check("ovr_held_valid", m_valid, 1);
      check("ovr_pulse_count", ovr_cnt - ovr0, 1);
      ready_val = 1'b1;
      idle(3);
      check("ovr_consumed_valid", m_valid, 0);
      wait_drain("t4", 50);

`ifdef UART_RX_PARITY_EN
      // 5: parity checking
      send_frame(8'h07, 1'b0, 1'b1, 1'b1);
      idle(CPP);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      wait_drain("t5", 300);
`endif

      // 6: reset in the middle of DATA bit 4
      d = 8'h5A;
      hold_bit(1'b0);
      for (int i = 0; i < 4; i++) hold_bit(d[i]);
      rx = d[4];
      repeat (CPP / 2) @(posedge clk);
      #1;
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #2;
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_data_out", data_out, 0);
      check("mid_rst_frame_err", frame_err, 0);
      check("mid_rst_parity_err", parity_err, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_busy", busy, 0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2 * CPP);
      check("post_rst_no_word", m_valid, 0);
      send_frame(8'h81, good_parity(8'h81), 1'b1, 1'b1);
      wait_drain("t6", 300);

      // Random traffic with a randomly stalling consumer
      ready_force = 1'b0;
      ovr0 = ovr_cnt;
      for (int n = 0; n < 20; n++) begin
         d    = DW'($urandom_range(0, (1 << DW) - 1));
         sb_v = ($urandom_range(0, 4) != 0);
         pb   = ($urandom_range(0, 3) != 0) ? good_parity(d) : ~good_parity(d);
         send_frame(d, pb, sb_v, 1'b1);
         if (!sb_v) idle(2 * CPP);
         else       idle($urandom_range(0, CPP));
      end
      ready_force = 1'b1;
      ready_val   = 1'b1;
      wait_drain("random", 500);
      check("random_no_overrun", ovr_cnt - ovr0, 0);

      idle(10);
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
